signed_at_feeder: RTL
=====================

# signed_at_feeder

Operand sequencer on the transmit side of the signed adder-tree accumulator (AT). Accepts packed activation/sign beats from the line buffer over a valid/ready handshake and registers them onto the AT operand bus. Drives the AT clear and enable for one configured accumulation window. Pulses `acc_done` in the first cycle the AT output register holds the complete window sum.

## Interface
- `PWO`, 32, output-width lanes per beat
- `PCI`, 4, input-channel lanes per beat; lane count `L = PWO*PCI`
- `CNT_W`, 16, width of the beat-length counter

- `clk`  in  1  rising-edge clock, single domain
- `reset`  in  1  synchronous, active-low (sampled on `clk`; `reset==0` resets)
- `start`  in  1  begin a window; sampled only in IDLE
- `cfg_len`  in  CNT_W  beats in the window; captured with `start`
- `in_valid`  in  1  beat offered
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `in_a`  in  4*L  4-bit activation per lane; lane j at `[4j+:4]`
- `in_b`  in  L  sign per lane: 0 adds `+a`, 1 adds `-a`
- `at_a`  out  4*L  registered operand to AT `A`
- `at_b`  out  L  registered operand to AT `B`
- `at_en`  out  1  AT accumulate enable
- `at_clear`  out  1  AT clear, drives the active-high AT reset
- `busy`  out  1  high in any state except IDLE
- `acc_done`  out  1  one-cycle pulse; AT output is final

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: `start=1` captures `cfg_len` into `remaining` and moves to CLEAR. `start` is ignored in every other state.
- CLEAR: `at_clear=1` for exactly one cycle, then STREAM.
  - If `remaining==0`, go directly to DONE. The window sum is 0.
- STREAM: `in_ready = (remaining != 0)`. This is a pure function of state and counter, with no combinational path from `in_valid`.
  - On each handshake: `at_a<=in_a`, `at_b<=in_b`, `at_en<=1`, `remaining<=remaining-1`.
  - With no handshake: `at_en<=0`, and `at_a`/`at_b` hold their values.
  - When the final beat is accepted (`remaining==1` at handshake), go to DRAIN.
- DRAIN: one cycle. `at_en` is high for the final beat while the AT adds it. Then DONE.
- DONE: `acc_done=1` for one cycle, `busy=1`, then IDLE.
- Beat order and content pass through unmodified. The feeder performs no arithmetic on operands.
- `cfg_len` is not checked against AT headroom. Keeping the window within range is the caller's responsibility.

## Timing
- Reset values: `in_ready=0`, `at_a=0`, `at_b=0`, `at_en=0`, `at_clear=0`, `busy=0`, `acc_done=0`, state=IDLE, `remaining=0`.
- Cycle sequence for a window of N beats:
  - `start` in cycle c → CLEAR in c+1.
  - First `in_ready` in c+2.
  - Handshake in cycle h → `at_en` high in h+1 → AT sum updated at the end of h+1.
  - Last handshake in cycle h_N → DRAIN h_N+1 → `acc_done` in h_N+2, coinciding with a valid AT output.
- With no stalls, latency from `start` to `acc_done` is N+3 cycles. Gaps in `in_valid` add cycles 1:1.
- `at_en` is never high in CLEAR, DONE or IDLE. `at_clear` and `at_en` are never high together.
- `start` in DONE is ignored. A new `start` is accepted in IDLE the cycle after DONE, so back-to-back windows are separated by one idle cycle.
- Reset mid-window: on the next edge, all outputs return to reset values and any accepted beat is dropped. The AT is not cleared by the reset itself; the next window's CLEAR does that.
- `in_valid` changing while `in_ready=0` has no effect.

## Structure
- Shared package `at_pkg`:
  - state enum
  - `L = PWO*PCI`
  - `A_W = 4*L`
- Sub-module `beat_down_counter` (CNT_W):
  - inputs: load, load value, decrement
  - outputs: `zero`, `one`
- FSM and operand registers stay in the top module.

## Test plan
- Reset (`reset=0`) for 2 cycles, then release → all outputs 0, `busy=0`.
- `cfg_len=4`, `in_valid` held high, all lanes a=3, b=0 → `at_clear` pulses in c+1, `at_en` high for 4 cycles, `acc_done` in c+7. AT output = 4·128·3 = 1536 (mod 2^12).
- `cfg_len=3`, `in_valid` toggled 1,0,1,0,1 → exactly 3 handshakes, `at_en` mirrors them one cycle later, `acc_done` two cycles after the third handshake.
- `cfg_len=0` → CLEAR, then DONE; `acc_done` at c+2, no `in_ready`, no `at_en`.
- `cfg_len=2`, lanes a=5, b alternating 0/1 → beat passthrough bit-exact, AT sum 0. `start` pulsed mid-STREAM is ignored.
- Reset asserted while `remaining=2` → next cycle idle with all outputs 0. A new `cfg_len=1` window completes correctly.

Source files
------------

// File: rtl/signed_at_feeder_pkg.sv
// Shared types and default sizing for the adder-tree operand feeder.
package at_pkg;
   localparam int PWO_DEF   = 32;
   localparam int PCI_DEF   = 4;
   localparam int CNT_W_DEF = 16;
   localparam int L         = PWO_DEF * PCI_DEF;
   localparam int A_W       = 4 * L;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;
endpackage

// File: rtl/signed_at_feeder_if.sv
// Line-buffer beat handshake plus AT operand/control bus; master is the line-buffer/controller side.
interface signed_at_feeder_if
   import at_pkg::*;
#(
   parameter int PWO   = PWO_DEF,
   parameter int PCI   = PCI_DEF,
   parameter int CNT_W = CNT_W_DEF
) ();
   logic                     start;
   logic [CNT_W-1:0]         cfg_len;
   logic                     in_valid;
   logic                     in_ready;
   logic [4*PWO*PCI-1:0]     in_a;
   logic [PWO*PCI-1:0]       in_b;
   logic [4*PWO*PCI-1:0]     at_a;
   logic [PWO*PCI-1:0]       at_b;
   logic                     at_en;
   logic                     at_clear;
   logic                     busy;
   logic                     acc_done;

   modport master (
      output start, cfg_len, in_valid, in_a, in_b,
      input  in_ready, at_a, at_b, at_en, at_clear, busy, acc_done
   );

   modport slave (
      input  start, cfg_len, in_valid, in_a, in_b,
      output in_ready, at_a, at_b, at_en, at_clear, busy, acc_done
   );
endinterface

// File: rtl/signed_at_feeder_beat_down_counter.sv
// Beats-remaining counter: loads the window length, steps down once per accepted beat.
// Flags are registered-state decodes, so in_ready never depends on in_valid.
module beat_down_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero,
   output logic             one
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);
   assign one  = (cnt == CNT_W'(1));
endmodule

// File: rtl/signed_at_feeder.sv
// Sequences one accumulation window onto the AT: clear, N registered beats, one drain cycle, done pulse.
// Beat to at_en is one cycle; stalls on in_valid add cycles 1:1, in_ready is a pure state/counter decode.
module signed_at_feeder
   import at_pkg::*;
#(
   parameter int PWO   = PWO_DEF,
   parameter int PCI   = PCI_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   signed_at_feeder_if.slave bus
);
   localparam int LANES = PWO * PCI;
   localparam int AW    = 4 * LANES;

   state_t           state;
   state_t           next_state;
   logic             ready;
   logic             hs;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic             cnt_one;
   logic [AW-1:0]    a_q;
   logic [LANES-1:0] b_q;
   logic             en_q;

   beat_down_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (bus.cfg_len),
      .dec      (cnt_dec),
      .zero     (cnt_zero),
      .one      (cnt_one)
   );

   assign hs = bus.in_valid & ready;

   always_comb begin
      next_state = state;
      ready      = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               cnt_load   = 1'b1;
               next_state = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            next_state = cnt_zero ? ST_DONE : ST_STREAM;
         end
         ST_STREAM: begin
            ready = ~cnt_zero;
            if (hs) begin
               cnt_dec = 1'b1;
               if (cnt_one) begin
                  next_state = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: next_state = ST_DONE;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Operands hold across stalls; only at_en tells the AT whether to add them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q  <= '0;
         b_q  <= '0;
         en_q <= 1'b0;
      end else begin
         en_q <= hs;
         if (hs) begin
            a_q <= bus.in_a;
            b_q <= bus.in_b;
         end
      end
   end

   assign bus.in_ready = ready;
   assign bus.at_a     = a_q;
   assign bus.at_b     = b_q;
   assign bus.at_en    = en_q;
   assign bus.at_clear = (state == ST_CLEAR);
   assign bus.busy     = (state != ST_IDLE);
   assign bus.acc_done = (state == ST_DONE);
endmodule
